// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if
// Bundles the signals exchanged between the datapath and the hazard/stall
// controller.
//   master : the datapath side. It drives the ID/EX observations and
//            receives the enables, flushes and MULT/DIV status.
//   slave  : the controller side (hazard_stall_ctrl).
// Signals:
//   rsD, rtD, branchD, pcsrcD, mdD, mfhiloD        ID-stage observations
//   writeregE, regwriteE, memtoregE                EX-stage observations
//   md_startE, md_divE                             MULT/DIV launch in EX
//   mem_wait                                       data-memory wait state
//   enableF, enableD, enableE, flushD, flushE      pipeline control
//   md_busy, md_done                               MULT/DIV status
interface hazard_stall_ctrl_if;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic       branchD;
  logic       pcsrcD;
  logic       mdD;
  logic       mfhiloD;
  logic [4:0] writeregE;
  logic       regwriteE;
  logic       memtoregE;
  logic       md_startE;
  logic       md_divE;
  logic       mem_wait;
  logic       enableF;
  logic       enableD;
  logic       enableE;
  logic       flushD;
  logic       flushE;
  logic       md_busy;
  logic       md_done;

  modport master (
    output rsD, rtD, branchD, pcsrcD, mdD, mfhiloD,
    output writeregE, regwriteE, memtoregE, md_startE, md_divE, mem_wait,
    input  enableF, enableD, enableE, flushD, flushE, md_busy, md_done
  );

  modport slave (
    input  rsD, rtD, branchD, pcsrcD, mdD, mfhiloD,
    input  writeregE, regwriteE, memtoregE, md_startE, md_divE, mem_wait,
    output enableF, enableD, enableE, flushD, flushE, md_busy, md_done
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Hazard and stall controller for the 5-stage MIPS pipeline. It detects
// load-use and branch-operand hazards, tracks the multi-cycle MULT/DIV unit
// and freezes the whole pipeline during data-memory wait states. It is the
// only driver of the IF/ID and ID/EX enable/flush controls.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : hazard_stall_ctrl_if.slave (ID/EX observations in, pipeline
//          controls and MULT/DIV status out)
// Parameters:
//   MULT_CYCLES : MULT/MULTU latency, 1..63
//   DIV_CYCLES  : DIV/DIVU latency, 1..63
//
// MULT/DIV state table
//   state | meaning
//   IDLE  | unit free; a start in EX (without mem_wait) launches an operation
//   BUSY  | unit computing; cnt counts down, cnt==0 is the final busy cycle
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 32
) (
  input logic              clk,
  input logic              rst,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  md_state_t  state_q;
  md_state_t  state_d;
  logic [5:0] cnt_q;
  logic [5:0] cnt_d;

  logic busy;
  logic reg_match;
  logic lu_haz;
  logic br_haz;
  logic md_haz;
  logic stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start seen while BUSY is a protocol violation and is dropped; a start
  // during mem_wait is dropped because EX re-presents it once memory is ready.
  // The countdown itself ignores mem_wait so the unit's latency is fixed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.md_startE && !bus.mem_wait) begin
          state_d = BUSY;
          cnt_d   = bus.md_divE ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  assign busy        = (state_q == BUSY);
  assign bus.md_busy = busy;
  assign bus.md_done = busy && (cnt_q == 6'd0);

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign reg_match = (bus.writeregE != 5'd0) &&
                     ((bus.writeregE == bus.rsD) || (bus.writeregE == bus.rtD));

  assign lu_haz = bus.memtoregE && bus.regwriteE && reg_match;
  assign br_haz = bus.branchD && bus.regwriteE && reg_match;
  assign md_haz = (busy || bus.md_startE) && (bus.mfhiloD || bus.mdD);
  assign stall  = lu_haz || br_haz || md_haz;

  // Stall beats a taken-branch flush: the branch stays in ID and is
  // re-resolved next cycle with forwarded operands.
  always_comb begin
    bus.enableF = 1'b1;
    bus.enableD = 1'b1;
    bus.enableE = 1'b1;
    bus.flushD  = 1'b0;
    bus.flushE  = 1'b0;
    if (rst) begin
      bus.enableF = 1'b1;
      bus.enableD = 1'b1;
      bus.enableE = 1'b1;
    end else if (bus.mem_wait) begin
      bus.enableF = 1'b0;
      bus.enableD = 1'b0;
      bus.enableE = 1'b0;
    end else begin
      bus.enableF = !stall;
      bus.enableD = !stall;
      bus.flushE  = stall;
      bus.flushD  = bus.pcsrcD && !stall;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
// Directed scenarios with hand-derived expectations, followed by randomized
// traffic compared every cycle against a behavioural model of the controller.
module tb_hazard_stall_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: number of busy cycles still to come, including the current one.
  int md_left = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst)
      md_left <= 0;
    else if (md_left > 0)
      md_left <= md_left - 1;
    else if (bus.md_startE && !bus.mem_wait)
      md_left <= bus.md_divE ? DIV_N : MULT_N;
  end

  // {enableF, enableD, enableE, flushD, flushE, md_busy, md_done}
  function automatic logic [6:0] model_out();
    logic busy_m, done_m, dep, stall_m;
    logic enf, end_, ene, fld, fle;
    busy_m = (md_left > 0);
    done_m = (md_left == 1);
    dep = (bus.writeregE != 0) &&
          (bus.writeregE == bus.rsD || bus.writeregE == bus.rtD);
    stall_m = (bus.memtoregE && bus.regwriteE && dep) ||
              (bus.branchD && bus.regwriteE && dep) ||
              ((busy_m || bus.md_startE) && (bus.mfhiloD || bus.mdD));
    if (rst) begin
      enf = 1; end_ = 1; ene = 1; fld = 0; fle = 0;
    end else if (bus.mem_wait) begin
      enf = 0; end_ = 0; ene = 0; fld = 0; fle = 0;
    end else begin
      enf = !stall_m; end_ = !stall_m; ene = 1;
      fld = bus.pcsrcD && !stall_m; fle = stall_m;
    end
    return {enf, end_, ene, fld, fle, busy_m, done_m};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [6:0] e;
      e = model_out();
      check("m_enableF", bus.enableF, e[6]);
      check("m_enableD", bus.enableD, e[5]);
      check("m_enableE", bus.enableE, e[4]);
      check("m_flushD",  bus.flushD,  e[3]);
      check("m_flushE",  bus.flushE,  e[2]);
      if (!rst) begin
        check("m_md_busy", bus.md_busy, e[1]);
        check("m_md_done", bus.md_done, e[0]);
      end
    end
  end

  task automatic clear_inputs();
    bus.rsD = 0; bus.rtD = 0; bus.branchD = 0; bus.pcsrcD = 0;
    bus.mdD = 0; bus.mfhiloD = 0; bus.writeregE = 0; bus.regwriteE = 0;
    bus.memtoregE = 0; bus.md_startE = 0; bus.md_divE = 0; bus.mem_wait = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    sample();
    check("rst_busy", bus.md_busy, 1'b0);
    check("rst_done", bus.md_done, 1'b0);
    check("rst_enableF", bus.enableF, 1'b1);
    check("rst_flushE", bus.flushE, 1'b0);
    tick();

    // Load-use on rs
    bus.memtoregE = 1; bus.regwriteE = 1; bus.writeregE = 8; bus.rsD = 8;
    sample();
    check("lu_enableF", bus.enableF, 1'b0);
    check("lu_enableD", bus.enableD, 1'b0);
    check("lu_flushE", bus.flushE, 1'b1);
    check("lu_enableE", bus.enableE, 1'b1);
    tick();
    clear_inputs();
    sample();
    check("lu_after_enableD", bus.enableD, 1'b1);
    check("lu_after_flushE", bus.flushE, 1'b0);
    tick();
    bus.memtoregE = 1; bus.regwriteE = 1; bus.writeregE = 0; bus.rsD = 0;
    sample();
    check("lu_r0_enableD", bus.enableD, 1'b1);
    check("lu_r0_flushE", bus.flushE, 1'b0);
    tick();
    clear_inputs();

    // Branch operand hazard beats taken-branch flush
    bus.pcsrcD = 1; bus.branchD = 1; bus.regwriteE = 1; bus.writeregE = 5; bus.rtD = 5;
    sample();
    check("br_flushD", bus.flushD, 1'b0);
    check("br_enableD", bus.enableD, 1'b0);
    check("br_flushE", bus.flushE, 1'b1);
    tick();
    bus.regwriteE = 0;
    sample();
    check("br_clear_flushD", bus.flushD, 1'b1);
    check("br_clear_enableD", bus.enableD, 1'b1);
    tick();
    clear_inputs();

    // MULT then MFHI held in ID
    for (int c = 0; c <= 6; c++) begin
      bus.md_startE = (c == 0); bus.md_divE = 0; bus.mfhiloD = 1;
      sample();
      check($sformatf("mfhi_busy_c%0d", c), bus.md_busy, (c >= 1 && c <= 5));
      check($sformatf("mfhi_done_c%0d", c), bus.md_done, (c == 5));
      check($sformatf("mfhi_enD_c%0d", c), bus.enableD, (c == 6));
      tick();
    end
    clear_inputs();
    tick();

    // DIV with 3-cycle mem_wait mid-operation
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c <= 40; c++) begin
      bus.md_startE = (c == 0); bus.md_divE = 1;
      bus.mem_wait = (c >= 5 && c <= 7);
      bus.mfhiloD = 1; bus.pcsrcD = 1;
      sample();
      busy_cnt += int'(bus.md_busy);
      done_cnt += int'(bus.md_done);
      if (c >= 5 && c <= 7) begin
        check("mw_enableF", bus.enableF, 1'b0);
        check("mw_enableD", bus.enableD, 1'b0);
        check("mw_enableE", bus.enableE, 1'b0);
        check("mw_flushD", bus.flushD, 1'b0);
        check("mw_flushE", bus.flushE, 1'b0);
      end
      tick();
    end
    check_int("mw_busy_cycles", busy_cnt, 32);
    check_int("mw_done_pulses", done_cnt, 1);
    clear_inputs();

    // Reset at busy cycle 10 of a DIV
    for (int c = 0; c <= 10; c++) begin
      bus.md_startE = (c == 0); bus.md_divE = 1; bus.mfhiloD = 1;
      rst = (c == 10);
      sample();
      if (c == 10) begin
        check("rstmid_enableD", bus.enableD, 1'b1);
        check("rstmid_enableF", bus.enableF, 1'b1);
        check("rstmid_flushE", bus.flushE, 1'b0);
      end
      tick();
    end
    rst = 1'b0;
    sample();
    check("rstmid_busy_after", bus.md_busy, 1'b0);
    check("rstmid_enableD_after", bus.enableD, 1'b1);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      sample();
      done_cnt += int'(bus.md_done);
      tick();
    end
    check_int("rstmid_no_done", done_cnt, 0);
    clear_inputs();

    // Illegal start while BUSY is ignored
    for (int c = 0; c <= 8; c++) begin
      bus.md_startE = (c == 0 || c == 2); bus.md_divE = (c == 2);
      sample();
      check($sformatf("ill_busy_c%0d", c), bus.md_busy, (c >= 1 && c <= 5));
      check($sformatf("ill_done_c%0d", c), bus.md_done, (c == 5));
      tick();
    end
    clear_inputs();

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      bus.rsD        = 5'($urandom_range(0, 3));
      bus.rtD        = 5'($urandom_range(0, 3));
      bus.writeregE  = 5'($urandom_range(0, 3));
      bus.branchD    = ($urandom_range(0, 3) == 0);
      bus.pcsrcD     = ($urandom_range(0, 3) == 0);
      bus.mdD        = ($urandom_range(0, 7) == 0);
      bus.mfhiloD    = ($urandom_range(0, 5) == 0);
      bus.regwriteE  = ($urandom_range(0, 1) == 0);
      bus.memtoregE  = ($urandom_range(0, 2) == 0);
      bus.md_startE  = ($urandom_range(0, 9) == 0);
      bus.md_divE    = ($urandom_range(0, 3) == 0);
      bus.mem_wait   = ($urandom_range(0, 6) == 0);
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    repeat (3) tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
